// File: rtl/ai_writeback_if.sv
// Ai result stream from the alpha-update datapath plus the alpha RAM write port.
// master: stream source and RAM arbiter side; slave: the writeback block.
interface ai_writeback_if #(
  parameter int ADDR_W = 10
);
  logic [31:0]       in_ai;
  logic              in_sop;
  logic [ADDR_W-1:0] in_idx;
  logic              ram_req;
  logic              ram_gnt;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;

  modport slave (
    input  in_ai, in_sop, in_idx, ram_gnt,
    output ram_req, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output in_ai, in_sop, in_idx, ram_gnt,
    input  ram_req, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ai_writeback.sv
// Clamps Ai results to 0 <= alpha <= C, queues them with their SVM index and
// writes them into the alpha RAM through a request/grant handshake.
//
// state | meaning
// IDLE  | FIFO empty, no request outstanding
// REQ   | ram_req held high, waiting for ram_gnt
// WRITE | ram_we pulse cycle; head already popped
module ai_writeback #(
  parameter int          ADDR_W = 10,
  parameter int          DEPTH  = 4,
  parameter logic [29:0] C_MAG  = 30'h0010_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ai_writeback_if.slave            bus,
  input  logic                     clr,
  output logic                     overflow,
  output logic                     clamp_hi,
  output logic [$clog2(DEPTH):0]   pending,
  output logic [15:0]              wr_cnt
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + 32;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  localparam logic [31:0] ZERO_WORD = 32'h8000_0000;

  logic [1:0]         state;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [31:0]        clamped;
  logic               clamp_evt;
  logic [ENTRY_W-1:0] head;

  // Anything that is not a strictly positive magnitude collapses to canonical zero.
  always_comb begin
    clamped   = ZERO_WORD;
    clamp_evt = 1'b0;
    if (bus.in_ai[31:30] == 2'b00 && bus.in_ai[29:0] != '0) begin
      if (bus.in_ai[29:0] > C_MAG) begin
        clamped   = {2'b00, C_MAG};
        clamp_evt = 1'b1;
      end else begin
        clamped = bus.in_ai;
      end
    end
  end

  // A pop on the same edge never frees space for a push while full.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push    = bus.in_sop && !full;
  assign pop     = (state == REQ) && bus.ram_gnt && !empty;
  assign head    = mem[rd_ptr];
  assign pending = count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.in_idx, clamped};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.ram_req   <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= ZERO_WORD;
      wr_cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            state       <= REQ;
            bus.ram_req <= 1'b1;
          end
        end
        REQ: begin
          if (pop) begin
            bus.ram_we    <= 1'b1;
            bus.ram_addr  <= head[ENTRY_W-1:32];
            bus.ram_wdata <= head[31:0];
            bus.ram_req   <= 1'b0;
            state         <= WRITE;
          end
        end
        WRITE: begin
          bus.ram_we <= 1'b0;
          if (wr_cnt != 16'hFFFF) begin
            wr_cnt <= wr_cnt + 16'd1;
          end
          if (!empty) begin
            state       <= REQ;
            bus.ram_req <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          bus.ram_req <= 1'b0;
          bus.ram_we  <= 1'b0;
        end
      endcase
    end
  end

  // A new event on the same edge as clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      clamp_hi <= 1'b0;
    end else begin
      overflow <= (overflow && !clr) || (bus.in_sop && full);
      clamp_hi <= (clamp_hi && !clr) || (push && clamp_evt);
    end
  end

endmodule

// File: tb/tb_ai_writeback.sv
// Directed bench for ai_writeback with a queue-based reference model checked
// every cycle at the falling edge.
module tb_ai_writeback;

  localparam int          ADDR_W = 10;
  localparam int          DEPTH  = 4;
  localparam logic [29:0] C_MAG  = 30'h0010_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        overflow;
  logic        clamp_hi;
  logic [2:0]  pending;
  logic [15:0] wr_cnt;

  int checks   = 0;
  int failures = 0;

  ai_writeback_if #(.ADDR_W(ADDR_W)) bus ();

  ai_writeback #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .C_MAG(C_MAG)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .clr      (clr),
    .overflow (overflow),
    .clamp_hi (clamp_hi),
    .pending  (pending),
    .wr_cnt   (wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_clamp(input logic [31:0] ai);
    if (ai[31:30] != 2'b00) return 32'h8000_0000;
    if (ai[29:0] == 30'd0) return 32'h8000_0000;
    if (ai[29:0] > C_MAG) return {2'b00, C_MAG};
    return ai;
  endfunction

  // Reference model: a queue of {idx, word}; a granted request removes the head.
  logic [ADDR_W+31:0] mq[$];
  logic               m_ovf, m_clamp, m_wpend;
  int                 m_wr;
  logic [ADDR_W-1:0]  m_addr;
  logic [31:0]        m_wdata;
  logic               s_rst = 1'b0;
  logic               s_sop, s_clr, s_hs;
  logic [31:0]        s_ai;
  logic [ADDR_W-1:0]  s_idx;

  always @(negedge clk) begin
    logic exp_we;
    logic ovf_evt, clamp_evt;
    logic [ADDR_W+31:0] e;
    int old_size;
    exp_we    = 1'b0;
    ovf_evt   = 1'b0;
    clamp_evt = 1'b0;
    if (!rst_n) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_clamp = 1'b0;
      m_wpend = 1'b0;
      m_wr    = 0;
      m_addr  = '0;
      m_wdata = 32'h8000_0000;
    end else if (s_rst) begin
      if (m_wpend) begin
        if (m_wr < 65535) m_wr++;
        m_wpend = 1'b0;
      end
      old_size = mq.size();
      if (s_hs) begin
        exp_we = 1'b1;
        if (old_size == 0) begin
          checks++;
          failures++;
          $display("FAIL grant_on_empty: request granted with %0d queued, required at least 1", old_size);
        end else begin
          e       = mq.pop_front();
          m_addr  = e[ADDR_W+31:32];
          m_wdata = e[31:0];
          m_wpend = 1'b1;
        end
      end
      if (s_sop) begin
        if (old_size < DEPTH) begin
          mq.push_back({s_idx, model_clamp(s_ai)});
          clamp_evt = (s_ai[31:30] == 2'b00) && (s_ai[29:0] > C_MAG);
        end else begin
          ovf_evt = 1'b1;
        end
      end
      m_ovf   = (m_ovf && !s_clr) || ovf_evt;
      m_clamp = (m_clamp && !s_clr) || clamp_evt;
    end
    chk("m_ram_we", 32'(bus.ram_we), 32'(exp_we));
    chk("m_ram_addr", 32'(bus.ram_addr), 32'(m_addr));
    chk("m_ram_wdata", bus.ram_wdata, m_wdata);
    chk("m_pending", 32'(pending), 32'(mq.size()));
    chk("m_overflow", 32'(overflow), 32'(m_ovf));
    chk("m_clamp_hi", 32'(clamp_hi), 32'(m_clamp));
    chk("m_wr_cnt", 32'(wr_cnt), 32'(m_wr));
    s_rst = rst_n;
    s_sop = bus.in_sop;
    s_ai  = bus.in_ai;
    s_idx = bus.in_idx;
    s_clr = clr;
    s_hs  = bus.ram_req && bus.ram_gnt;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] ai, input logic [ADDR_W-1:0] idx, input logic clr_v);
    bus.in_sop = 1'b1;
    bus.in_ai  = ai;
    bus.in_idx = idx;
    clr        = clr_v;
    tick();
    bus.in_sop = 1'b0;
    clr        = 1'b0;
  endtask

  task automatic wait_we(output logic ok, input int budget);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.ram_we) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_expect(input string name, input logic [31:0] ai,
                             input logic [ADDR_W-1:0] idx, input logic [31:0] exp);
    logic ok;
    send(ai, idx, 1'b0);
    wait_we(ok, 8);
    chk({name, "_timeout"}, 32'(ok), 32'd1);
    if (ok) begin
      chk({name, "_wdata"}, bus.ram_wdata, exp);
      chk({name, "_addr"}, 32'(bus.ram_addr), 32'(idx));
    end
    tick();
    tick();
  endtask

  task automatic drain(input int cycles);
    bus.ram_gnt = 1'b1;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  initial begin
    int n, stall_bad, pulses;
    int idxs[4];
    int times[4];
    logic ok;

    bus.in_ai   = '0;
    bus.in_sop  = 1'b0;
    bus.in_idx  = '0;
    bus.ram_gnt = 1'b0;
    clr         = 1'b0;
    rst_n       = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ram_req", 32'(bus.ram_req), 32'd0);
    chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_ram_wdata", bus.ram_wdata, 32'h8000_0000);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_flags", {30'd0, overflow, clamp_hi}, 32'd0);
    chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // single word, grant tied high: ram_we high only after E+2
    bus.ram_gnt = 1'b1;
    send(32'h0000_0123, 10'd5, 1'b0);
    chk("single_we_e0", 32'(bus.ram_we), 32'd0);
    tick();
    chk("single_we_e1", 32'(bus.ram_we), 32'd0);
    chk("single_req_e1", 32'(bus.ram_req), 32'd1);
    tick();
    chk("single_we_e2", 32'(bus.ram_we), 32'd1);
    chk("single_addr", 32'(bus.ram_addr), 32'd5);
    chk("single_wdata", bus.ram_wdata, 32'h0000_0123);
    tick();
    chk("single_we_e3", 32'(bus.ram_we), 32'd0);
    chk("single_wr_cnt", 32'(wr_cnt), 32'd1);
    tick();

    // clamp cases
    send_expect("clamp_neg", 32'h4000_0010, 10'd1, 32'h8000_0000);
    chk("clamp_hi_after_neg", 32'(clamp_hi), 32'd0);
    send_expect("clamp_upper", 32'h0020_0000, 10'd2, 32'h0010_0000);
    chk("clamp_hi_set", 32'(clamp_hi), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clamp_hi_clr", 32'(clamp_hi), 32'd0);
    send_expect("clamp_zero", 32'h0000_0000, 10'd3, 32'h8000_0000);
    send_expect("clamp_invalid", 32'hC000_0001, 10'd4, 32'h8000_0000);
    send_expect("clamp_code10", 32'h8000_0005, 10'd6, 32'h8000_0000);
    send_expect("clamp_at_c", 32'h0010_0000, 10'd7, 32'h0010_0000);
    chk("clamp_hi_at_c", 32'(clamp_hi), 32'd0);
    send_expect("pass_one", 32'h0000_0001, 10'd8, 32'h0000_0001);
    send(32'h0030_0000, 10'd9, 1'b1);
    chk("clamp_set_beats_clr", 32'(clamp_hi), 32'd1);
    wait_we(ok, 8);
    chk("clamp_clr_timeout", 32'(ok), 32'd1);
    chk("clamp_clr_wdata", bus.ram_wdata, 32'h0010_0000);
    tick();
    tick();
    chk("wr_cnt_after_clamps", 32'(wr_cnt), 32'd9);

    // back-pressure, overflow and a long grant stall
    bus.ram_gnt = 1'b0;
    for (int i = 0; i < 6; i++) send(32'h100 + 32'(i), 10'(i), i >= 4);
    chk("bp_pending", 32'(pending), 32'd4);
    chk("bp_overflow", 32'(overflow), 32'd1);
    stall_bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!bus.ram_req || bus.ram_we) stall_bad++;
    end
    chk("bp_stall_cycles_bad", 32'(stall_bad), 32'd0);
    bus.ram_gnt = 1'b1;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.ram_we) begin
        if (n < 4) begin
          idxs[n]  = int'(bus.ram_addr);
          times[n] = c;
        end
        n++;
      end
    end
    chk("bp_write_count", 32'(n), 32'd4);
    for (int k = 0; k < 4; k++) chk("bp_write_idx", 32'(idxs[k]), 32'(k));
    for (int k = 1; k < 4; k++) chk("bp_write_gap", 32'(times[k] - times[k-1]), 32'd2);

    // single grant stall: exactly one pulse once granted
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    bus.ram_gnt = 1'b0;
    send(32'h0000_0777, 10'd40, 1'b0);
    tick();
    stall_bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!bus.ram_req || bus.ram_we) stall_bad++;
    end
    chk("stall_cycles_bad", 32'(stall_bad), 32'd0);
    bus.ram_gnt = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.ram_we) pulses++;
    end
    chk("stall_pulses", 32'(pulses), 32'd1);

    // full FIFO: pop and push on the same edge drops the push
    bus.ram_gnt = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h200 + 32'(i), 10'(10 + i), 1'b0);
    tick();
    chk("full_pending", 32'(pending), 32'd4);
    chk("full_ovf_before", 32'(overflow), 32'd0);
    bus.ram_gnt = 1'b1;
    send(32'h0000_02FF, 10'd9, 1'b0);
    bus.ram_gnt = 1'b0;
    chk("collide_we", 32'(bus.ram_we), 32'd1);
    chk("collide_addr", 32'(bus.ram_addr), 32'd10);
    chk("collide_pending", 32'(pending), 32'd3);
    chk("collide_overflow", 32'(overflow), 32'd1);
    bus.ram_gnt = 1'b1;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.ram_we) begin
        chk("collide_drain_idx", 32'(bus.ram_addr), 32'(11 + n));
        n++;
      end
    end
    chk("collide_drain_count", 32'(n), 32'd3);

    // pending=2: simultaneous push and pop keep occupancy
    bus.ram_gnt = 1'b0;
    send(32'h0000_0301, 10'd20, 1'b0);
    send(32'h0000_0302, 10'd21, 1'b0);
    tick();
    chk("pp_pending_before", 32'(pending), 32'd2);
    bus.ram_gnt = 1'b1;
    send(32'h0000_0303, 10'd22, 1'b0);
    bus.ram_gnt = 1'b0;
    chk("pp_we", 32'(bus.ram_we), 32'd1);
    chk("pp_pending_after", 32'(pending), 32'd2);
    drain(10);
    chk("pp_drained", 32'(pending), 32'd0);

    // reset while requesting with three entries queued
    bus.ram_gnt = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h0000_0400 + 32'(i), 10'(30 + i), 1'b0);
    tick();
    chk("mid_req_before", 32'(bus.ram_req), 32'd1);
    chk("mid_pending_before", 32'(pending), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(bus.ram_req), 32'd0);
    chk("mid_rst_pending", 32'(pending), 32'd0);
    chk("mid_rst_we", 32'(bus.ram_we), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.ram_gnt = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.ram_we || bus.ram_req) n++;
    end
    chk("mid_no_write_after", 32'(n), 32'd0);
    chk("mid_wr_cnt", 32'(wr_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ai_writeback.md
Name: ai_writeback

Overview:
- Receiving end of the Ai result stream from the alpha-update datapath.
- Captures each Ai word on its one-cycle start-of-packet strobe, together with its SVM index.
- Applies the SVM box constraint 0 <= alpha <= C in the team's sign-magnitude format, buffers results in a small FIFO, and writes them back to the alpha RAM write port through a request/grant handshake.
- Sits between the Ai accumulator and the alpha RAM arbiter.

Parameters:
- ADDR_W, 10, width of the SVM index / alpha RAM address.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- C_MAG, 30'h0010_0000, upper bound C, as a 30-bit magnitude.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_ai  in  32  Ai word: [31:30] 00=positive, 01=negative, 10=zero, 11=invalid; [29:0] magnitude
- in_sop  in  1  one-cycle strobe; in_ai and in_idx are valid this cycle
- in_idx  in  ADDR_W  SVM index of the Ai word
- ram_gnt  in  1  arbiter grant for the alpha RAM write port
- ram_req  out  1  write-port request
- ram_we  out  1  one-cycle write enable
- ram_addr  out  ADDR_W  write address
- ram_wdata  out  32  clamped alpha word
- clr  in  1  synchronous clear of the sticky status flags
- overflow  out  1  sticky; an Ai was dropped because the FIFO was full
- clamp_hi  out  1  sticky; an upper clamp occurred
- pending  out  log2(DEPTH)+1  FIFO occupancy
- wr_cnt  out  16  completed writes, saturating at 16'hFFFF

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state IDLE, FIFO empty, pending=0;
  - ram_req=0, ram_we=0, ram_addr=0, ram_wdata=32'h8000_0000;
  - overflow=0, clamp_hi=0, wr_cnt=0.
  - Reset mid-operation discards all queued entries and any in-flight request.
- Clamp (combinational, applied on the push path):
  - code 01 (negative) -> 32'h8000_0000.
  - code 10 or 11 -> 32'h8000_0000.
  - code 00 with magnitude 0 -> 32'h8000_0000 (canonical zero).
  - code 00 with magnitude > C_MAG -> {2'b00, C_MAG}, and clamp_hi is set.
  - code 00 with magnitude 1..C_MAG -> passed unchanged.
- Push:
  - At a rising edge with in_sop=1 and the FIFO not full, store {in_idx, clamped word}.
  - If in_sop=1 while full, drop the word, set overflow, and leave the FIFO unchanged.
  - A push and a pop on the same edge are both honoured; pending is unchanged.
  - While full, a simultaneous pop does NOT make room for that cycle's push; the word is dropped.
- FSM:
  - IDLE: if pending>0 at the edge, go to REQ and set ram_req<=1.
  - REQ: hold ram_req=1 until ram_gnt is sampled high. On that edge:
    - ram_we<=1, ram_addr/ram_wdata<=FIFO head;
    - pop the FIFO; ram_req<=0;
    - go to WRITE.
  - WRITE: ram_we<=0 and increment wr_cnt (saturating). Then:
    - if pending>0 (after the pop), go to REQ with ram_req<=1;
    - else go to IDLE.
  - ram_addr/ram_wdata hold their last values outside WRITE.
- Latency and throughput:
  - With ram_gnt tied high, an in_sop sampled at edge E gives ram_we high from edge E+2 to E+3.
  - Sustained throughput is one write per 2 cycles.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo DEPTH.
  - Full/empty are derived from an occupancy count of log2(DEPTH)+1 bits.
- Status flags:
  - clr clears overflow and clamp_hi.
  - If clr coincides with a new overflow or clamp event, the set wins.
  - wr_cnt is not cleared by clr.

Test Plan:
- Single word: in_ai=32'h0000_0123, idx=5, gnt tied 1, sop at edge E -> ram_we high at E+2 only; addr=5, wdata=32'h0000_0123; wr_cnt=1.
- Clamp cases: in_ai=32'h4000_0010 -> 32'h8000_0000; in_ai=32'h0020_0000 -> 32'h0010_0000 with clamp_hi=1; in_ai=32'h0000_0000 -> 32'h8000_0000; in_ai=32'hC000_0001 -> 32'h8000_0000.
- Back-pressure and overflow: gnt=0, 6 sops with idx 0..5 -> pending=4, overflow=1. Then gnt=1 -> exactly idx 0..3 written in order, one per 2 cycles.
- Grant stall: hold gnt=0 for 10 cycles after the request -> ram_req stays 1 and ram_we stays 0. Raise gnt -> ram_we pulses exactly once.
- Push/pop collision: pending=4 (full), WRITE pop and new sop on the same edge -> new word dropped, overflow=1. With pending=2, a simultaneous push and pop leave pending at 2.
- Reset mid-operation: rst_n low while in REQ with 3 entries queued -> immediately ram_req=0, pending=0. After release, no write occurs without a new sop.
